// File: rtl/cpu_defs.sv
// Shared definitions for the CPU fetch/sequencing logic: opcodes, reset PC
// and the fetch state encoding.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] HALT_OP  = 6'b111111;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_EXEC,
    FETCH_PAUSE,
    FETCH_HALT
  } fetch_state_t;

  function automatic logic is_halt(input logic [31:0] inst);
    return inst[31:26] == HALT_OP;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
// Kept standalone so a later pipelined fetch can reuse it unchanged.
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic        unused_opcode;

  assign pc_plus4      = pc + 32'd4;
  assign branch_off    = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign unused_opcode = ^inst[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing controller: owns the PC, fetches over a
// req/ack handshake and presents each instruction for one commit cycle.
module fetch_sequencer
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic        jump,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic        halted,
  output logic        busy
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  inst_reg, inst_next;
  logic [31:0]  npc;

  npc_calc u_npc_calc (
    .pc           (pc_reg),
    .inst         (inst_reg),
    .branch_taken (branch_taken),
    .jump         (jump),
    .next_pc      (npc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH_IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    unique case (state_reg)
      FETCH_IDLE: begin
        if (start) state_next = FETCH_REQ;
      end
      FETCH_REQ: begin
        // Data is only captured here; acks in any other state are ignored.
        if (imem_ack) begin
          inst_next  = imem_rdata;
          state_next = FETCH_EXEC;
        end
      end
      FETCH_EXEC: begin
        if (is_halt(inst_reg)) begin
          state_next = FETCH_HALT;
        end else begin
          pc_next    = npc;
          state_next = step_mode ? FETCH_PAUSE : FETCH_REQ;
        end
      end
      FETCH_PAUSE: begin
        if (step || !step_mode) state_next = FETCH_REQ;
      end
      FETCH_HALT: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = FETCH_REQ;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops imem_req immediately.
  assign imem_req   = (state_reg == FETCH_REQ);
  assign imem_addr  = pc_reg;
  assign inst       = inst_reg;
  assign pc         = pc_reg;
  assign inst_valid = (state_reg == FETCH_EXEC) && !is_halt(inst_reg);
  assign halted     = (state_reg == FETCH_HALT);
  assign busy       = (state_reg == FETCH_REQ) || (state_reg == FETCH_EXEC) ||
                      (state_reg == FETCH_PAUSE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each task drives one scenario and checks
// the outputs inline against hand-computed values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        halted;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .step_mode    (step_mode),
    .step         (step),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .jump         (jump),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .halted       (halted),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (pc !== 32'h0)        begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++; if (inst !== 32'h0)      begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL idle_no_start got %b exp 0", imem_req); end
    $display("test_reset: pc=%h busy=%b", pc, busy);
  endtask

  task automatic test_fetch_same_cycle();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
    tick();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", inst_valid); end
    checks++; if (inst !== 32'h2001_0005) begin errors++; $display("FAIL first_inst got %h exp 20010005", inst); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL exec_pc got %h exp 0", pc); end
    tick();
    checks++; if (pc !== 32'h4 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL after_first got pc=%h v=%b req=%b exp 4/0/1", pc, inst_valid, imem_req); end
    $display("test_fetch_same_cycle: inst=%h pc=%h", inst, pc);
  endtask

  task automatic test_wait_ack();
    int req_cycles = 0;
    int valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req === 1'b1) req_cycles++;
      if (inst_valid === 1'b1) valid_cycles++;
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL wait_addr got %h exp 4", imem_addr); end
      imem_ack = (i == 3); imem_rdata = (i == 3) ? 32'h0000_0020 : 32'hDEAD_BEEF;
      tick();
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (inst_valid === 1'b1) valid_cycles++;
      tick();
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL wait_req_cycles got %0d exp 4", req_cycles); end
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL wait_valid_pulses got %0d exp 1", valid_cycles); end
    checks++; if (inst !== 32'h0000_0020) begin errors++; $display("FAIL wait_inst got %h exp 00000020", inst); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL wait_pc got %h exp 8", pc); end
    $display("test_wait_ack: req_cycles=%0d pc=%h", req_cycles, pc);
  endtask

  // From REQ: fetch one word with same-cycle ack, drive branch/jump during EXEC.
  task automatic fetch_one(input logic [31:0] word, input logic br, input logic jp);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; branch_taken = br; jump = jp;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
  endtask

  task automatic test_branch_jump();
    fetch_one(32'h0, 1'b0, 1'b0);
    fetch_one(32'h0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_pc got %h exp 10", pc); end
    fetch_one(32'h1000_FFFE, 1'b1, 1'b0);
    checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL branch_pc got %h exp 0c", pc); end
    fetch_one(32'h1000_FFFE, 1'b0, 1'b0);
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL not_taken_pc got %h exp 10", pc); end
    fetch_one(32'h0800_0040, 1'b1, 1'b1);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc got %h exp 100", pc); end
    $display("test_branch_jump: pc=%h", pc);
  endtask

  task automatic test_step();
    int valid_cycles = 0;
    step_mode = 1'b1;
    fetch_one(32'h0, 1'b0, 1'b0);
    checks++; if (imem_req !== 1'b0 || busy !== 1'b1 || pc !== 32'h104) begin
      errors++; $display("FAIL pause_enter got req=%b busy=%b pc=%h exp 0/1/104", imem_req, busy, pc); end
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pause_hold got %b exp 0", imem_req); end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL step_release got %b exp 1", imem_req); end
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 0);
      imem_rdata = 32'h0;
      if (inst_valid === 1'b1) valid_cycles++;
      tick();
    end
    imem_ack = 1'b0;
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL step_valid_pulses got %0d exp 1", valid_cycles); end
    checks++; if (imem_req !== 1'b0 || pc !== 32'h108) begin
      errors++; $display("FAIL step_dropped got req=%b pc=%h exp 0/108", imem_req, pc); end
    step_mode = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL step_mode_off got %b exp 1", imem_req); end
    $display("test_step: pc=%h", pc);
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    tick();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b exp 0", inst_valid); end
    tick();
    checks++; if (halted !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_state got halted=%b busy=%b exp 1/0", halted, busy); end
    checks++; if (pc !== 32'h108) begin errors++; $display("FAIL halt_pc got %h exp 108", pc); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    checks++; if (inst !== 32'hFC00_0000) begin errors++; $display("FAIL halt_late_ack got %h exp fc000000", inst); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (imem_req !== 1'b1 || pc !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL restart got req=%b pc=%h halted=%b exp 1/0/0", imem_req, pc, halted); end
    $display("test_halt: restart pc=%h", pc);
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req got %b exp 0", imem_req); end
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    tick();
    imem_ack = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle got req=%b busy=%b v=%b exp 0/0/0", imem_req, busy, inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL post_rst_inst got %h exp 0", inst); end
    $display("test_reset_mid_req: inst=%h busy=%b", inst, busy);
  endtask

  initial begin
    test_reset();
    test_fetch_same_cycle();
    test_wait_ack();
    test_branch_jump();
    test_step();
    test_halt();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
